// File: rtl/fetch_seq.sv
// Program counter and instruction-fetch sequencer: walks the instruction ROM,
// resolves JMP/BEQ/HLT, and runs the start/done handshake with the harness.
module fetch_seq #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [8:0]       Instr,
   input  logic             Stall,
   input  logic             BranchFlag,
   input  logic [PC_W-1:0]  LutTarget,
   output logic [PC_W-1:0]  InstrAddr,
   output logic [4:0]       Opcode,
   output logic [3:0]       Operand,
   output logic [3:0]       LutIdx,
   output logic             InstrValid,
   output logic             Done,
   output logic             Illegal,
   output logic [CNT_W-1:0] CycleCount
);

   localparam logic [4:0] OP_BEQ    = 5'd17;
   localparam logic [4:0] OP_JMP    = 5'd18;
   localparam logic [4:0] OP_HLT    = 5'd19;
   localparam logic [4:0] OP_ILL_LO = 5'd20;

   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic              ill_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [4:0]        op;

   assign op = Instr[8:4];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         InstrAddr  <= '0;
         Illegal    <= 1'b0;
         CycleCount <= '0;
      end else begin
         state      <= state_nxt;
         InstrAddr  <= pc_nxt;
         Illegal    <= ill_nxt;
         CycleCount <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = InstrAddr;
      ill_nxt   = Illegal;
      cnt_nxt   = CycleCount;
      case (state)
         IDLE, HALTED: begin
            if (Start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
               ill_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            // Stalled cycles still count as RUN time
            if (CycleCount != '1) cnt_nxt = CycleCount + 1'b1;
            if (!Stall) begin
               if (op == OP_HLT) begin
                  state_nxt = HALTED;
               end else if (op == OP_JMP || (op == OP_BEQ && BranchFlag)) begin
                  pc_nxt = LutTarget;
               end else begin
                  if (op >= OP_ILL_LO) ill_nxt = 1'b1;
                  pc_nxt = InstrAddr + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign InstrValid = (state == RUN);
   assign Done       = (state == HALTED);

   // Outside RUN the decoder sees a HLT so it never commits side effects
   assign Opcode  = InstrValid ? Instr[8:4] : OP_HLT;
   assign Operand = InstrValid ? Instr[3:0] : 4'd0;
   assign LutIdx  = Instr[3:0];

endmodule
